// File: rtl/ddr2_cmd_arbiter.sv
// Round-robin arbiter sharing one DDR2 MIG app interface between a write and a read
// requester; sequences write-data/command handshakes and tracks outstanding reads.
module ddr2_cmd_arbiter #(
    parameter int ADDR_W  = 27,
    parameter int DATA_W  = 128,
    parameter int MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    input  logic              app_rdy,
    input  logic              app_wdf_rdy,
    input  logic              app_rd_data_valid,
    input  logic [DATA_W-1:0] app_rd_data,
    output logic              app_en,
    output logic [2:0]        app_cmd,
    output logic [ADDR_W-1:0] app_addr,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    output logic [DATA_W-1:0] app_wdf_data
);
    localparam int               CNT_W    = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [2:0]       CMD_WR   = 3'b000;
    localparam logic [2:0]       CMD_RD   = 3'b001;
    localparam logic             GRANT_WR = 1'b0;
    localparam logic             GRANT_RD = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_DATA = 2'd1,
        WR_CMD  = 2'd2,
        RD_CMD  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] wr_addr_lat_q, wr_addr_lat_d;
    logic              wr_ack_q, wr_ack_d;
    logic              rd_ack_q, rd_ack_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              busy_q, busy_d;
    logic              app_en_q, app_en_d;
    logic [2:0]        app_cmd_q, app_cmd_d;
    logic [ADDR_W-1:0] app_addr_q, app_addr_d;
    logic              app_wdf_wren_q, app_wdf_wren_d;
    logic [DATA_W-1:0] app_wdf_data_q, app_wdf_data_d;

    logic wr_elig_s, rd_elig_s, grant_wr_s, grant_rd_s, cnt_inc_s, cnt_dec_s;

    // The ack guard keeps a requester still holding req in its ack cycle from a second grant.
    assign wr_elig_s  = wr_req && !wr_ack_q;
    assign rd_elig_s  = rd_req && !rd_ack_q && (cnt_q != CNT_MAX);
    assign grant_wr_s = wr_elig_s && (!rd_elig_s || (last_grant_q == GRANT_RD));
    assign grant_rd_s = rd_elig_s && !grant_wr_s;
    assign cnt_dec_s  = app_rd_data_valid && (cnt_q != '0);

    // Next-state, next-output and outstanding-count computation.
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        wr_addr_lat_d  = wr_addr_lat_q;
        app_en_d       = app_en_q;
        app_cmd_d      = app_cmd_q;
        app_addr_d     = app_addr_q;
        app_wdf_wren_d = app_wdf_wren_q;
        app_wdf_data_d = app_wdf_data_q;
        wr_ack_d       = 1'b0;
        rd_ack_d       = 1'b0;
        cnt_inc_s      = 1'b0;
        rd_valid_d     = app_rd_data_valid;
        rd_data_d      = app_rd_data;
        busy_d         = (state_q != IDLE) || (cnt_q != '0);

        case (state_q)
            IDLE: begin
                if (grant_wr_s) begin
                    last_grant_d   = GRANT_WR;
                    wr_addr_lat_d  = wr_addr;
                    app_wdf_data_d = wr_data;
                    app_wdf_wren_d = 1'b1;
                    state_d        = WR_DATA;
                end else if (grant_rd_s) begin
                    last_grant_d = GRANT_RD;
                    app_en_d     = 1'b1;
                    app_cmd_d    = CMD_RD;
                    app_addr_d   = rd_addr;
                    state_d      = RD_CMD;
                end else begin
                    state_d = IDLE;
                end
            end
            WR_DATA: begin
                if (app_wdf_rdy) begin
                    app_wdf_wren_d = 1'b0;
                    app_en_d       = 1'b1;
                    app_cmd_d      = CMD_WR;
                    app_addr_d     = wr_addr_lat_q;
                    state_d        = WR_CMD;
                end else begin
                    state_d = WR_DATA;
                end
            end
            WR_CMD: begin
                if (app_rdy) begin
                    app_en_d = 1'b0;
                    wr_ack_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    state_d = WR_CMD;
                end
            end
            RD_CMD: begin
                if (app_rdy) begin
                    app_en_d  = 1'b0;
                    rd_ack_d  = 1'b1;
                    cnt_inc_s = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d = RD_CMD;
                end
            end
            default: begin
                app_en_d       = 1'b0;
                app_wdf_wren_d = 1'b0;
                state_d        = IDLE;
            end
        endcase

        if (cnt_inc_s && !cnt_dec_s) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (cnt_dec_s && !cnt_inc_s) begin
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and output registers; last_grant resets to READ so write wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            last_grant_q   <= GRANT_RD;
            cnt_q          <= '0;
            wr_addr_lat_q  <= '0;
            wr_ack_q       <= 1'b0;
            rd_ack_q       <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_data_q      <= '0;
            busy_q         <= 1'b0;
            app_en_q       <= 1'b0;
            app_cmd_q      <= 3'b000;
            app_addr_q     <= '0;
            app_wdf_wren_q <= 1'b0;
            app_wdf_data_q <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            cnt_q          <= cnt_d;
            wr_addr_lat_q  <= wr_addr_lat_d;
            wr_ack_q       <= wr_ack_d;
            rd_ack_q       <= rd_ack_d;
            rd_valid_q     <= rd_valid_d;
            rd_data_q      <= rd_data_d;
            busy_q         <= busy_d;
            app_en_q       <= app_en_d;
            app_cmd_q      <= app_cmd_d;
            app_addr_q     <= app_addr_d;
            app_wdf_wren_q <= app_wdf_wren_d;
            app_wdf_data_q <= app_wdf_data_d;
        end
    end

    assign wr_ack       = wr_ack_q;
    assign rd_ack       = rd_ack_q;
    assign rd_valid     = rd_valid_q;
    assign rd_data      = rd_data_q;
    assign busy         = busy_q;
    assign app_en       = app_en_q;
    assign app_cmd      = app_cmd_q;
    assign app_addr     = app_addr_q;
    assign app_wdf_wren = app_wdf_wren_q;
    assign app_wdf_end  = app_wdf_wren_q;
    assign app_wdf_data = app_wdf_data_q;

endmodule

// File: tb/tb_ddr2_cmd_arbiter.sv
// Directed bench for ddr2_cmd_arbiter: a cycle table for write/read/alternation plus
// hand sequences for read saturation, MIG stalls and reset mid-handshake.
module tb_ddr2_cmd_arbiter;
    localparam int ADDR_W  = 27;
    localparam int DATA_W  = 128;
    localparam int MAX_OUT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_req, rd_req, wr_ack, rd_ack, rd_valid, busy;
    logic [ADDR_W-1:0] wr_addr, rd_addr, app_addr;
    logic [DATA_W-1:0] wr_data, rd_data, app_rd_data, app_wdf_data;
    logic              app_rdy, app_wdf_rdy, app_rd_data_valid;
    logic              app_en, app_wdf_wren, app_wdf_end;
    logic [2:0]        app_cmd;

    always #5 clk = ~clk;

    ddr2_cmd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .reset(reset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
        .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data_valid(app_rd_data_valid), .app_rd_data(app_rd_data),
        .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_data(app_wdf_data)
    );

    typedef struct {
        logic              wr_req;
        logic              rd_req;
        logic [ADDR_W-1:0] wr_addr;
        logic [ADDR_W-1:0] rd_addr;
        logic              exp_wren;
        logic              exp_en;
        logic [2:0]        exp_cmd;
        logic              exp_wr_ack;
        logic              exp_rd_ack;
        logic              exp_busy;
        logic [ADDR_W-1:0] exp_addr;
    } vec_t;

    vec_t tbl[19];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   acks;
    logic [DATA_W-1:0] pat_a5;
    logic [DATA_W-1:0] pat_e;

    task automatic chkw(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0b, want %0b", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic w, input logic r,
                                input logic [ADDR_W-1:0] wa, input logic [ADDR_W-1:0] ra,
                                input logic ewr, input logic een, input logic [2:0] ecmd,
                                input logic ewa, input logic era, input logic eb,
                                input logic [ADDR_W-1:0] eaddr);
        vec_t v;
        v.wr_req = w;      v.rd_req = r;      v.wr_addr = wa;     v.rd_addr = ra;
        v.exp_wren = ewr;  v.exp_en = een;    v.exp_cmd = ecmd;
        v.exp_wr_ack = ewa; v.exp_rd_ack = era; v.exp_busy = eb;  v.exp_addr = eaddr;
        return v;
    endfunction

    task automatic apply_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            wr_req  = tbl[i].wr_req;
            rd_req  = tbl[i].rd_req;
            wr_addr = tbl[i].wr_addr;
            rd_addr = tbl[i].rd_addr;
            step();
            chk1($sformatf("row%0d wren", i), app_wdf_wren, tbl[i].exp_wren);
            chk1($sformatf("row%0d wdf_end", i), app_wdf_end, tbl[i].exp_wren);
            chk1($sformatf("row%0d app_en", i), app_en, tbl[i].exp_en);
            chkw($sformatf("row%0d app_cmd", i), 128'(app_cmd), 128'(tbl[i].exp_cmd));
            chkw($sformatf("row%0d app_addr", i), 128'(app_addr), 128'(tbl[i].exp_addr));
            chk1($sformatf("row%0d wr_ack", i), wr_ack, tbl[i].exp_wr_ack);
            chk1($sformatf("row%0d rd_ack", i), rd_ack, tbl[i].exp_rd_ack);
            chk1($sformatf("row%0d busy", i), busy, tbl[i].exp_busy);
            if (tbl[i].exp_wren) chkw($sformatf("row%0d wdf_data", i), app_wdf_data, pat_a5);
        end
    endtask

    initial begin
        pat_a5 = {16{8'hA5}};
        pat_e  = {4{32'hDEADBEEF}};
        // Single write (0x100), single read (0x200): wr rd wa ra | wren en cmd wack rack busy addr
        tbl[0]  = mk(1'b1, 1'b0, 27'h100, 27'h200, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 27'h0);
        tbl[1]  = mk(1'b1, 1'b0, 27'h100, 27'h200, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 27'h100);
        tbl[2]  = mk(1'b1, 1'b0, 27'h100, 27'h200, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 27'h100);
        tbl[3]  = mk(1'b1, 1'b0, 27'h100, 27'h200, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 27'h100);
        tbl[4]  = mk(1'b0, 1'b0, 27'h100, 27'h200, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 27'h100);
        tbl[5]  = mk(1'b0, 1'b1, 27'h100, 27'h200, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 27'h200);
        tbl[6]  = mk(1'b0, 1'b1, 27'h100, 27'h200, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 1'b1, 27'h200);
        tbl[7]  = mk(1'b0, 1'b1, 27'h100, 27'h200, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 27'h200);
        tbl[8]  = mk(1'b0, 1'b0, 27'h100, 27'h200, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 27'h200);
        // Both requests held: W,R,W,R
        tbl[9]  = mk(1'b1, 1'b1, 27'hABCDEF, 27'h123456, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 27'h200);
        tbl[10] = mk(1'b1, 1'b1, 27'hABCDEF, 27'h123456, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 27'hABCDEF);
        tbl[11] = mk(1'b1, 1'b1, 27'hABCDEF, 27'h123456, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 27'hABCDEF);
        tbl[12] = mk(1'b1, 1'b1, 27'hABCDEF, 27'h123456, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 27'h123456);
        tbl[13] = mk(1'b1, 1'b1, 27'hABCDEF, 27'h123456, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 1'b1, 27'h123456);
        tbl[14] = mk(1'b1, 1'b1, 27'hABCDEF, 27'h123456, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 27'h123456);
        tbl[15] = mk(1'b1, 1'b1, 27'hABCDEF, 27'h123456, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 27'hABCDEF);
        tbl[16] = mk(1'b1, 1'b1, 27'hABCDEF, 27'h123456, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 27'hABCDEF);
        tbl[17] = mk(1'b1, 1'b1, 27'hABCDEF, 27'h123456, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 27'h123456);
        tbl[18] = mk(1'b1, 1'b1, 27'hABCDEF, 27'h123456, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 1'b1, 27'h123456);

        reset = 1'b1; wr_req = 1'b0; rd_req = 1'b0; wr_addr = '0; rd_addr = '0;
        wr_data = pat_a5; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        app_rd_data_valid = 1'b0; app_rd_data = '0;
        for (int i = 0; i < 3; i++) step();
        chk1("rst app_en", app_en, 1'b0);
        chk1("rst wren", app_wdf_wren, 1'b0);
        chk1("rst wr_ack", wr_ack, 1'b0);
        chk1("rst rd_ack", rd_ack, 1'b0);
        chk1("rst rd_valid", rd_valid, 1'b0);
        chk1("rst busy", busy, 1'b0);
        chkw("rst app_cmd", 128'(app_cmd), 128'(3'd0));
        chkw("rst app_addr", 128'(app_addr), 128'(27'h0));
        reset = 1'b0;

        apply_rows(0, 8);
        // Read beat returned 10 cycles after the accept edge
        for (int i = 0; i < 7; i++) begin
            step();
            chk1("rdret idle rd_valid", rd_valid, 1'b0);
        end
        app_rd_data_valid = 1'b1; app_rd_data = 128'h1234;
        step();
        chk1("rdret rd_valid", rd_valid, 1'b1);
        chkw("rdret rd_data", rd_data, 128'h1234);
        app_rd_data_valid = 1'b0;
        step();
        chk1("rdret rd_valid drop", rd_valid, 1'b0);
        chk1("rdret busy clear", busy, 1'b0);

        wr_data = pat_a5;
        apply_rows(9, 18);
        wr_req = 1'b0; rd_req = 1'b0;
        app_rd_data_valid = 1'b1; app_rd_data = 128'hBEEF1;
        step();
        chkw("alt beat1", rd_data, 128'hBEEF1);
        chk1("alt beat1 valid", rd_valid, 1'b1);
        app_rd_data = 128'hBEEF2;
        step();
        chkw("alt beat2", rd_data, 128'hBEEF2);
        app_rd_data_valid = 1'b0;
        step();
        chk1("alt busy clear", busy, 1'b0);

        // Saturation: four reads issue, the fifth waits for a returned beat
        rd_req = 1'b1; rd_addr = 27'h300; acks = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (rd_ack) acks++;
        end
        chkw("sat ack count", 128'(acks), 128'(4));
        chk1("sat stalled en", app_en, 1'b0);
        chk1("sat busy", busy, 1'b1);
        app_rd_data_valid = 1'b1; app_rd_data = 128'h55;
        step();
        chk1("sat beat no grant yet", app_en, 1'b0);
        chk1("sat beat valid", rd_valid, 1'b1);
        app_rd_data_valid = 1'b0;
        step();
        chk1("sat fifth en", app_en, 1'b1);
        chkw("sat fifth cmd", 128'(app_cmd), 128'(3'd1));
        step();
        chk1("sat fifth ack", rd_ack, 1'b1);
        rd_req = 1'b0;
        step();
        chk1("sat ack single", rd_ack, 1'b0);
        app_rd_data_valid = 1'b1;
        for (int i = 0; i < 4; i++) step();
        app_rd_data_valid = 1'b0;
        step(); step();
        chk1("sat drained busy", busy, 1'b0);

        // Write with app_wdf_rdy low 5 edges then app_rdy low 3 edges
        wr_req = 1'b1; wr_addr = 27'h1234; wr_data = pat_e; app_wdf_rdy = 1'b0; app_rdy = 1'b0;
        step();
        chk1("stall e0 wren", app_wdf_wren, 1'b1);
        for (int e = 1; e <= 10; e++) begin
            app_wdf_rdy = (e >= 6);
            app_rdy     = (e >= 10);
            step();
            chk1($sformatf("stall e%0d wren", e), app_wdf_wren, (e <= 5));
            chk1($sformatf("stall e%0d en", e), app_en, (e >= 6 && e <= 9));
            chk1($sformatf("stall e%0d wr_ack", e), wr_ack, (e == 10));
            if (e <= 5) chkw($sformatf("stall e%0d data", e), app_wdf_data, pat_e);
            if (e >= 6 && e <= 9) chkw($sformatf("stall e%0d addr", e), 128'(app_addr), 128'(27'h1234));
        end
        wr_req = 1'b0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        step();
        chk1("stall ack single", wr_ack, 1'b0);

        // Reset in WR_CMD with one read outstanding
        rd_req = 1'b1; rd_addr = 27'h400;
        step(); step();
        rd_req = 1'b0;
        step();
        wr_req = 1'b1; wr_addr = 27'h500; app_rdy = 1'b0;
        step(); step();
        chk1("rstmid en before", app_en, 1'b1);
        step();
        reset = 1'b1;
        step();
        chk1("rstmid app_en", app_en, 1'b0);
        chk1("rstmid wren", app_wdf_wren, 1'b0);
        chk1("rstmid wdf_end", app_wdf_end, 1'b0);
        chk1("rstmid wr_ack", wr_ack, 1'b0);
        chk1("rstmid busy", busy, 1'b0);
        chkw("rstmid app_cmd", 128'(app_cmd), 128'(3'd0));
        chkw("rstmid app_addr", 128'(app_addr), 128'(27'h0));
        chkw("rstmid wdf_data", app_wdf_data, 128'h0);
        reset = 1'b0; wr_req = 1'b0; app_rdy = 1'b1;
        step();
        chk1("rstmid after wr_ack", wr_ack, 1'b0);
        chk1("rstmid after en", app_en, 1'b0);
        chk1("rstmid after busy", busy, 1'b0);
        wr_req = 1'b1;
        step();
        chk1("reissue wren", app_wdf_wren, 1'b1);
        step();
        chk1("reissue en", app_en, 1'b1);
        chkw("reissue addr", 128'(app_addr), 128'(27'h500));
        step();
        chk1("reissue wr_ack", wr_ack, 1'b1);
        wr_req = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ddr2_cmd_arbiter.md
# ddr2_cmd_arbiter

Two-port arbiter and command sequencer that shares one DDR2 MIG user (app) interface between a write requester and a read requester. It grants the ports round-robin and drives the MIG write-data FIFO and command handshakes in the correct order. It tracks outstanding reads and returns read data to the read port. It sits between the tertiary-storage datapath clients and the MIG core, in the MIG `ui_clk` domain.

## Interface
- ADDR_W, 27, MIG app address width
- DATA_W, 128, MIG app data width (one beat per command, BL8 on x16)
- MAX_OUT, 4, maximum outstanding read commands; power of two, at most 16
- clk  in  1  MIG ui_clk; all logic on the rising edge
- reset  in  1  synchronous, active-high
- wr_req  in  1  write request; held with wr_addr/wr_data until wr_ack
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_ack  out  1  one-cycle pulse: write command accepted by MIG
- rd_req  in  1  read request; held with rd_addr until rd_ack
- rd_addr  in  ADDR_W  read address
- rd_ack  out  1  one-cycle pulse: read command accepted by MIG
- rd_valid  out  1  read data valid, one cycle per returned beat
- rd_data  out  DATA_W  read data
- busy  out  1  state != IDLE, or outstanding count != 0
- app_rdy, app_wdf_rdy  in  1  MIG command / write-FIFO ready
- app_rd_data_valid  in  1  MIG read beat valid
- app_rd_data  in  DATA_W  MIG read data
- app_en  out  1  command valid
- app_cmd  out  3  000 write, 001 read
- app_addr  out  ADDR_W  command address
- app_wdf_wren, app_wdf_end  out  1  write-data valid / last beat (always equal)
- app_wdf_data  out  DATA_W  write data

## Operation
- All outputs are registered. Reset values: every output is 0, state is IDLE, outstanding count is 0, last_grant is READ (so write wins the first tie).
- The FSM has four states: IDLE, WR_DATA, WR_CMD, RD_CMD.
- In IDLE, a port is eligible when req=1 and its ack=0. The ack guard stops a requester still holding req in the ack cycle from being granted twice.
- A read is also ineligible while outstanding == MAX_OUT.
- If both ports are eligible, the port other than last_grant wins. last_grant updates on every grant.
- Write grant:
  - Latch the address and data.
  - Set app_wdf_wren = app_wdf_end = 1 and drive app_wdf_data, then go to WR_DATA.
- WR_DATA: hold the write-data outputs. On a clock edge with app_wdf_rdy=1:
  - Clear wren/end.
  - Set app_en=1, app_cmd=000, app_addr=latched address.
  - Go to WR_CMD.
- WR_CMD: hold the command outputs. On an edge with app_rdy=1: set app_en=0, pulse wr_ack, go to IDLE.
- Read grant: set app_en=1, app_cmd=001, app_addr=rd_addr, then go to RD_CMD.
- RD_CMD: hold the command outputs. On an edge with app_rdy=1:
  - Set app_en=0 and pulse rd_ack.
  - Increment the outstanding count.
  - Go to IDLE.
- Read return: rd_valid/rd_data are app_rd_data_valid/app_rd_data registered by one cycle.
  - app_rd_data_valid decrements the outstanding count.
  - The count saturates at 0; stray beats are still forwarded.
- Increment and decrement on the same edge leave the count unchanged.
- app_cmd keeps its last value when app_en=0. Addresses and data are never changed while en/wren is high.
- Reset at any point, including mid-handshake: outputs drop to 0 on the next edge and the count clears. Requesters re-issue; no ack is produced for an aborted command.
- Invalid state encodings return to IDLE.

## Timing
- Request seen at edge N → app_en or app_wdf_wren is high from cycle N+1.
- Write with MIG always ready:
  - wren high in cycle N+1.
  - app_en high in cycle N+2.
  - wr_ack high in cycle N+3.
  - Back in IDLE in cycle N+3; the next grant is possible at edge N+4.
- Read with MIG always ready: app_en high in cycle N+1, rd_ack high in cycle N+2.
- app_rdy / app_wdf_rdy low stalls the FSM indefinitely with the outputs held stable.
- Read data latency = MIG latency + 1 cycle. Beats return in command order; there is no reordering.
- Arbitration cost is at most one extra IDLE cycle between commands.

## Test plan
- Single write, MIG ready, addr 0x0000100, data 0xA5…A5:
  - wren/end high in cycle 1; app_en with cmd 000 and addr 0x100 in cycle 2; wr_ack in cycle 3.
  - busy falls in cycle 3+1.
- Single read addr 0x0000200, app_rd_data_valid returned 10 cycles after accept with data 0x1234:
  - rd_ack pulses once; rd_valid=1 with rd_data=0x1234 one cycle after app_rd_data_valid.
  - Count returns to 0.
- wr_req and rd_req held high continuously: grants alternate W,R,W,R starting with write; each ack pulses exactly once per command.
- Five reads with app_rd_data_valid withheld: four rd_acks, then the fifth request stalls in IDLE. The first returned beat lets the fifth issue on the following grant.
- app_wdf_rdy low for 5 cycles, then app_rdy low for 3 cycles:
  - wren, then app_en, held stable throughout the stalls.
  - wr_ack arrives 8 cycles later than the unstalled case.
- reset asserted while in WR_CMD with app_rdy=0: all outputs 0 next cycle, no wr_ack, state IDLE, count 0.
